// File: rtl/ex_muldiv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ex_muldiv_ctrl                                             |
// | Description : Multi-cycle multiply/divide sequencer beside the EX-stage  |
// |               ALU. Owns HI/LO, runs shift-add multiply or restoring      |
// |               divide on operand magnitudes, then applies sign fix-up.    |
// |               Stalls the front of the pipe while a HI/LO access or a new |
// |               mul/div would collide with a running operation.            |
// | Option      : MULDIV_EARLY_OUT_EN - multiply leaves RUN as soon as the   |
// |               remaining multiplier bits are all zero.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ex_muldiv_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             MdStart_ex,
   input  logic [1:0]       MdOp_ex,
   input  logic [1:0]       MdWrite_ex,
   input  logic             MdRead_ex,
   input  logic             Flush_ex,
   input  logic [WIDTH-1:0] OpA_ex,
   input  logic [WIDTH-1:0] OpB_ex,
   output logic             Stall_ex,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_SIGN = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               div_zero;
   // Multiply: acc = running product, addend = shifted multiplicand, mplr = multiplier.
   // Divide:   acc = {remainder, dividend/quotient}, addend[WIDTH-1:0] = divisor.
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] addend;
   logic [WIDTH-1:0]   mplr;

   logic               accept;
   logic               last_iter;
   logic               early_out;

   // Operand preparation at issue
   logic               op_signed;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;

   // Iteration and result datapath
   logic [2*WIDTH-1:0] mul_step;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] div_step;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   assign Busy      = (state != S_IDLE);
   assign Stall_ex  = Busy & (MdStart_ex | MdRead_ex | (|MdWrite_ex));
   assign last_iter = (cnt == CNT_LAST);

   assign op_signed = ~MdOp_ex[0];
   assign sign_a    = op_signed & OpA_ex[WIDTH-1];
   assign sign_b    = op_signed & OpB_ex[WIDTH-1];
   assign abs_a     = sign_a ? (-OpA_ex) : OpA_ex;
   assign abs_b     = sign_b ? (-OpB_ex) : OpB_ex;

`ifdef MULDIV_EARLY_OUT_EN
   // Multiply may stop once no set multiplier bits remain beyond the one consumed now
   assign early_out = ~is_div & (mplr[WIDTH-1:1] == '0);
`else
   assign early_out = 1'b0;
`endif

   // Sequencer next-state and issue decision
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            if (MdStart_ex && !Flush_ex) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (last_iter || early_out) begin
               state_nxt = S_SIGN;
            end
         end
         S_SIGN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // One multiply/divide iteration and the sign-corrected final result
   always_comb begin
      mul_step = acc + (mplr[0] ? addend : '0);
      // Remainder shifted left with the next dividend bit brought in; one extra bit
      // because the shifted remainder can reach twice the divisor.
      rem_sh   = acc[2*WIDTH-1:WIDTH-1];
      diff     = rem_sh - {1'b0, addend[WIDTH-1:0]};
      if (diff[WIDTH]) begin
         div_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         div_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end

      prod_fix = neg_q ? (-acc) : acc;
      // Divide-by-zero results keep the raw latched dividend and all-ones quotient
      quo_fix  = (neg_q && !div_zero) ? (-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      rem_fix  = (neg_r && !div_zero) ? (-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];

      if (is_div) begin
         res_hi = rem_fix;
         res_lo = quo_fix;
      end else begin
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
         res_lo = prod_fix[WIDTH-1:0];
      end
   end

   // Sequencer state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Working registers: load magnitudes at issue, iterate while running
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         acc      <= '0;
         addend   <= '0;
         mplr     <= '0;
      end else if (accept) begin
         cnt      <= '0;
         is_div   <= MdOp_ex[1];
         neg_q    <= sign_a ^ sign_b;
         neg_r    <= sign_a;
         div_zero <= MdOp_ex[1] & (OpB_ex == '0);
         if (MdOp_ex[1]) begin
            acc    <= {{WIDTH{1'b0}}, abs_a};
            addend <= {{WIDTH{1'b0}}, abs_b};
            mplr   <= '0;
         end else begin
            acc    <= '0;
            addend <= {{WIDTH{1'b0}}, abs_a};
            mplr   <= abs_b;
         end
      end else if (state == S_RUN) begin
         cnt <= cnt + CNT_ONE;
         if (is_div) begin
            acc <= div_step;
         end else begin
            acc    <= mul_step;
            addend <= {addend[2*WIDTH-2:0], 1'b0};
            mplr   <= {1'b0, mplr[WIDTH-1:1]};
         end
      end
   end

   // HI/LO: result write in SIGN, MTHI/MTLO only in IDLE when not flushed or overridden by a start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         HI <= '0;
         LO <= '0;
      end else if (state == S_SIGN) begin
         HI <= res_hi;
         LO <= res_lo;
      end else if ((state == S_IDLE) && !MdStart_ex && !Flush_ex) begin
         if (MdWrite_ex[1]) begin
            HI <= OpA_ex;
         end
         if (MdWrite_ex[0]) begin
            LO <= OpA_ex;
         end
      end
   end

   // Done pulses in the cycle HI/LO first show a new result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Done <= 1'b0;
      end else begin
         Done <= (state == S_SIGN);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ex_muldiv_ctrl                                          |
// | Description : Scoreboard bench for ex_muldiv_ctrl. Issued operations     |
// |               push expected HI/LO/latency; a Done monitor pops/compares. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ex_muldiv_ctrl;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             MdStart_ex;
   logic [1:0]       MdOp_ex;
   logic [1:0]       MdWrite_ex;
   logic             MdRead_ex;
   logic             Flush_ex;
   logic [WIDTH-1:0] OpA_ex;
   logic [WIDTH-1:0] OpB_ex;
   logic             Stall_ex;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   ex_muldiv_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .MdStart_ex (MdStart_ex),
      .MdOp_ex    (MdOp_ex),
      .MdWrite_ex (MdWrite_ex),
      .MdRead_ex  (MdRead_ex),
      .Flush_ex   (Flush_ex),
      .OpA_ex     (OpA_ex),
      .OpB_ex     (OpB_ex),
      .Stall_ex   (Stall_ex),
      .Busy       (Busy),
      .Done       (Done),
      .HI         (HI),
      .LO         (LO)
   );

   always #5 clk = ~clk;

   // Count rising edges so latency is measured in cycles
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected accept-to-Done latency
   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      logic [31:0] m;
      int          msb;
      if (op[1]) return WIDTH + 1;
      m   = (!op[0] && b[31]) ? (-b) : b;
      msb = 0;
      for (int i = 0; i < 32; i++) if (m[i]) msb = i;
      return msb + 2;
`else
      return WIDTH + 1;
`endif
   endfunction

   // Monitor: every Done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && Done) begin
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL done_unexpected: Done=1 with empty scoreboard, expected no pulse");
         end else begin
            mon_e = sbq.pop_front();
            chk("result_hi", {32'h0, HI}, {32'h0, mon_e.hi});
            chk("result_lo", {32'h0, LO}, {32'h0, mon_e.lo});
            chk("latency", 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
         end
      end
   end

   // Issue a mul/div; holds the request through any stall with scrambled operands,
   // then presents the real operands in the accept cycle.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
      int   n;
      exp_t e;
      @(negedge clk);
      MdStart_ex = 1'b1;
      MdOp_ex    = op;
      OpA_ex     = a;
      OpB_ex     = b;
      n          = 0;
      if (Busy) begin
         #1 chk("stall_on_busy_start", {63'h0, Stall_ex}, 64'h1);
      end
      while (Busy && n < 200) begin
         OpA_ex = ~a;
         OpB_ex = ~b;
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("issue_timeout", {63'h0, Busy}, 64'h0);
      OpA_ex    = a;
      OpB_ex    = b;
      e.hi      = eh;
      e.lo      = el;
      e.lat     = exp_lat(op, b);
      e.acc_cyc = cyc + 1;
      sbq.push_back(e);
      @(negedge clk);
      MdStart_ex = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (Busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", {63'h0, Busy}, 64'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalled;
      int bad;
      exp_t e;

      rst_n      = 1'b0;
      MdStart_ex = 1'b1;
      MdOp_ex    = 2'b01;
      MdWrite_ex = 2'b00;
      MdRead_ex  = 1'b1;
      Flush_ex   = 1'b0;
      OpA_ex     = 32'h5;
      OpB_ex     = 32'h7;
      repeat (3) @(negedge clk);
      chk("reset_busy",  {63'h0, Busy},     64'h0);
      chk("reset_stall", {63'h0, Stall_ex}, 64'h0);
      chk("reset_done",  {63'h0, Done},     64'h0);
      chk("reset_hi",    {32'h0, HI},       64'h0);
      chk("reset_lo",    {32'h0, LO},       64'h0);
      MdStart_ex = 1'b0;
      MdRead_ex  = 1'b0;
      rst_n      = 1'b1;

      // Unsigned multiply, full-width operands
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      wait_idle();

      // Signed multiply with an MFLO held behind it
      issue(2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      MdRead_ex = 1'b1;
      stalled   = 0;
      bad       = 0;
      for (int n = 0; n < 100 && Busy; n++) begin
         #1;
         if (Stall_ex) stalled++;
         else bad++;
         @(negedge clk);
      end
      #1;
      chk("mflo_stall_gaps",  64'(bad), 64'h0);
      chk("mflo_stall_count", 64'(stalled), 64'(exp_lat(2'b00, 32'd3)));
      chk("mflo_release",     {63'h0, Stall_ex}, 64'h0);
      MdRead_ex = 1'b0;

      // Signed most-negative squared
      issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      wait_idle();

      // Divides: signed, by zero, overflow case, mixed signs, plain unsigned
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      wait_idle();
      issue(2'b11, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
      wait_idle();
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      wait_idle();
      issue(2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      wait_idle();
      issue(2'b10, 32'hFFFF_FFF8, 32'd0, 32'h0000_0008, 32'hFFFF_FFFF);
      wait_idle();
      issue(2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);
      wait_idle();

      // Second operation requested while the first runs
      issue(2'b01, 32'd6, 32'd7, 32'h0, 32'd42);
      issue(2'b11, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF);
      wait_idle();

      // MTHI in IDLE, then MFHI
      @(negedge clk);
      MdWrite_ex = 2'b10;
      OpA_ex     = 32'h1234;
      #1 chk("mthi_no_stall", {63'h0, Stall_ex}, 64'h0);
      @(negedge clk);
      MdWrite_ex = 2'b00;
      MdRead_ex  = 1'b1;
      #1 chk("mthi_value", {32'h0, HI}, 64'h1234);
      chk("mfhi_no_stall", {63'h0, Stall_ex}, 64'h0);
      MdRead_ex  = 1'b0;

      // MTHI and MTLO together
      @(negedge clk);
      MdWrite_ex = 2'b11;
      OpA_ex     = 32'hABCD;
      @(negedge clk);
      MdWrite_ex = 2'b00;
      #1 chk("mthilo_hi", {32'h0, HI}, 64'hABCD);
      chk("mthilo_lo", {32'h0, LO}, 64'hABCD);

      // Flushed MTHI/MTLO is dropped
      @(negedge clk);
      MdWrite_ex = 2'b11;
      OpA_ex     = 32'hFFFF;
      Flush_ex   = 1'b1;
      @(negedge clk);
      MdWrite_ex = 2'b00;
      Flush_ex   = 1'b0;
      #1 chk("flush_mt_hi", {32'h0, HI}, 64'hABCD);

      // Start together with a write: start wins, HI/LO unchanged while running
      @(negedge clk);
      MdStart_ex = 1'b1;
      MdOp_ex    = 2'b01;
      OpA_ex     = 32'd2;
      OpB_ex     = 32'd3;
      MdWrite_ex = 2'b11;
      e.hi       = 32'h0;
      e.lo       = 32'd6;
      e.lat      = exp_lat(2'b01, 32'd3);
      e.acc_cyc  = cyc + 1;
      sbq.push_back(e);
      @(negedge clk);
      MdStart_ex = 1'b0;
      MdWrite_ex = 2'b00;
      #1 chk("start_wins_hi", {32'h0, HI}, 64'hABCD);
      chk("start_wins_lo", {32'h0, LO}, 64'hABCD);
      wait_idle();

      // MTLO while busy: stalled, old LO visible, applied after Done
      issue(2'b01, 32'd4, 32'd5, 32'h0, 32'h14);
      MdWrite_ex = 2'b01;
      OpA_ex     = 32'h5555;
      #1 chk("busy_lo_stable", {32'h0, LO}, 64'h6);
      bad = 0;
      for (int n = 0; n < 100 && Busy; n++) begin
         #1;
         if (!Stall_ex) bad++;
         @(negedge clk);
      end
      chk("mtlo_busy_stall_gaps", 64'(bad), 64'h0);
      @(negedge clk);
      MdWrite_ex = 2'b00;
      #1 chk("mtlo_after_done_lo", {32'h0, LO}, 64'h5555);
      chk("mtlo_after_done_hi", {32'h0, HI}, 64'h0);

      // Asynchronous reset part-way through a DIVU
      @(negedge clk);
      MdStart_ex = 1'b1;
      MdOp_ex    = 2'b11;
      OpA_ex     = 32'd1000;
      OpB_ex     = 32'd3;
      @(negedge clk);
      MdStart_ex = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_reset_busy", {63'h0, Busy}, 64'h1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_busy", {63'h0, Busy}, 64'h0);
      chk("async_reset_lo", {32'h0, LO}, 64'h0);
      chk("async_reset_hi", {32'h0, HI}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Flushed start is not accepted
      @(negedge clk);
      MdStart_ex = 1'b1;
      MdOp_ex    = 2'b01;
      OpA_ex     = 32'd5;
      OpB_ex     = 32'd1;
      Flush_ex   = 1'b1;
      @(negedge clk);
      MdStart_ex = 1'b0;
      Flush_ex   = 1'b0;
      #1 chk("flush_no_accept", {63'h0, Busy}, 64'h0);

      // Small multiplier (early-out sensitive latency) and zero multiplier
      issue(2'b01, 32'd5, 32'd1, 32'h0, 32'd5);
      wait_idle();
      issue(2'b00, 32'd9, 32'd0, 32'h0, 32'h0);
      wait_idle();

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 64'(sbq.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
